// File: rtl/keypad_entry.sv
// Keypad number-entry front end: edge-detects key presses, decodes the 4x4 key
// map, accumulates BCD digits and raises single-cycle command pulses.
module keypad_entry #(
  parameter int DIGITS    = 4,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keydown,
  input  logic [3:0]            key_id,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CNT_W-1:0]      digit_count,
  output logic                  locked,
  output logic [4*DIGITS-1:0]   value,
  output logic                  value_valid,
  output logic                  start_pulse,
  output logic                  clear_pulse,
  output logic                  error_pulse
);

  typedef enum logic {S_EDIT, S_LOCKED} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_keydown_q;
  logic [4*DIGITS-1:0] r_digits, w_digits_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [4*DIGITS-1:0] r_value, w_value_nxt;
  logic                r_vv, r_start, r_clear, r_err;
  logic                w_vv, w_start, w_clear, w_err;

  logic                w_ev;
  logic                w_is_digit, w_is_start, w_is_clear, w_is_confirm;
  logic [3:0]          w_digit;
  logic [4*DIGITS-1:0] w_shift;

  assign w_ev = keydown & ~r_keydown_q;

  always_comb begin
    w_is_digit   = 1'b0;
    w_is_start   = 1'b0;
    w_is_clear   = 1'b0;
    w_is_confirm = 1'b0;
    w_digit      = 4'd0;
    case (key_id)
      4'd1:    begin w_is_digit = 1'b1; w_digit = 4'd1; end
      4'd2:    begin w_is_digit = 1'b1; w_digit = 4'd2; end
      4'd3:    begin w_is_digit = 1'b1; w_digit = 4'd3; end
      4'd5:    begin w_is_digit = 1'b1; w_digit = 4'd4; end
      4'd6:    begin w_is_digit = 1'b1; w_digit = 4'd5; end
      4'd7:    begin w_is_digit = 1'b1; w_digit = 4'd6; end
      4'd9:    begin w_is_digit = 1'b1; w_digit = 4'd7; end
      4'd10:   begin w_is_digit = 1'b1; w_digit = 4'd8; end
      4'd11:   begin w_is_digit = 1'b1; w_digit = 4'd9; end
      4'd13:   begin w_is_digit = 1'b1; w_digit = 4'd0; end
      4'd12:   w_is_confirm = 1'b1;
      4'd14:   w_is_start   = 1'b1;
      4'd15:   w_is_clear   = 1'b1;
      default: ;  // letter keys 0/4/8 fall through as invalid
    endcase
  end

  // A single-digit buffer has no older digits to keep, so the shift degenerates
  generate
    if (DIGITS == 1) begin : g_shift1
      assign w_shift = w_digit;
    end else begin : g_shiftn
      assign w_shift = {r_digits[4*DIGITS-5:0], w_digit};
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_count_nxt  = r_count;
    w_value_nxt  = r_value;
    w_vv         = 1'b0;
    w_start      = 1'b0;
    w_clear      = 1'b0;
    w_err        = 1'b0;
    if (w_ev) begin
      if (w_is_clear) begin
        w_digits_nxt = '0;
        w_count_nxt  = '0;
        w_state_nxt  = S_EDIT;
        w_clear      = 1'b1;
      end else if (w_is_start) begin
        w_start = 1'b1;
      end else if (!(w_is_digit || w_is_confirm) || r_state == S_LOCKED) begin
        w_err = 1'b1;
      end else if (w_is_digit) begin
        if (r_count < CNT_W'(DIGITS)) begin
          w_digits_nxt = w_shift;
          w_count_nxt  = r_count + CNT_W'(1);
        end else if (OVERWRITE != 0) begin
          w_digits_nxt = w_shift;
        end else begin
          w_err = 1'b1;
        end
      end else if (r_count != '0) begin
        w_value_nxt = r_digits;
        w_vv        = 1'b1;
        w_state_nxt = S_LOCKED;
      end else begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EDIT;
      r_keydown_q <= 1'b0;
      r_digits    <= '0;
      r_count     <= '0;
      r_value     <= '0;
      r_vv        <= 1'b0;
      r_start     <= 1'b0;
      r_clear     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_keydown_q <= keydown;
      r_digits    <= w_digits_nxt;
      r_count     <= w_count_nxt;
      r_value     <= w_value_nxt;
      r_vv        <= w_vv;
      r_start     <= w_start;
      r_clear     <= w_clear;
      r_err       <= w_err;
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign locked      = (r_state == S_LOCKED);
  assign value       = r_value;
  assign value_valid = r_vv;
  assign start_pulse = r_start;
  assign clear_pulse = r_clear;
  assign error_pulse = r_err;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: table of key presses with expected entry state, and a
// pulse scoreboard fed at press time and drained as the DUT emits pulses.
module tb_keypad_entry;

  localparam logic [3:0] P_VV = 4'b1000, P_ST = 4'b0100, P_CLR = 4'b0010, P_ERR = 4'b0001;

  logic        clk = 1'b0;
  logic        rst, keydown;
  logic [3:0]  key_id;
  logic [15:0] digits, value, digits1, value1;
  logic [2:0]  digit_count, digit_count1;
  logic        locked, value_valid, start_pulse, clear_pulse, error_pulse;
  logic        locked1, vv1, st1, clr1, err1;

  int checks = 0;
  int errors = 0;
  int ow_err = 0;
  logic [3:0] sb[$];

  keypad_entry #(.DIGITS(4), .OVERWRITE(0)) dut (
    .clk(clk), .rst(rst), .keydown(keydown), .key_id(key_id),
    .digits(digits), .digit_count(digit_count), .locked(locked), .value(value),
    .value_valid(value_valid), .start_pulse(start_pulse),
    .clear_pulse(clear_pulse), .error_pulse(error_pulse));

  keypad_entry #(.DIGITS(4), .OVERWRITE(1)) dut_ow (
    .clk(clk), .rst(rst), .keydown(keydown), .key_id(key_id),
    .digits(digits1), .digit_count(digit_count1), .locked(locked1), .value(value1),
    .value_valid(vv1), .start_pulse(st1), .clear_pulse(clr1), .error_pulse(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    int          hold;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic        lck;
    logic [15:0] val;
    logic [3:0]  pul;
    logic        chk_ow;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {value_valid, start_pulse, clear_pulse, error_pulse};
  endfunction

  // Scoreboard: every cycle with a pulse must match the oldest expected pulse
  always @(negedge clk) begin
    if (err1) ow_err++;
    if (pulses() != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'd0, pulses()}, 32'd0);
      end else begin
        chk("sb_pulse", {28'd0, pulses()}, {28'd0, sb.pop_front()});
      end
    end
  end

  task automatic add(input logic [3:0] id, input int hold, input logic [15:0] dig,
                     input logic [2:0] cnt, input logic lck, input logic [15:0] val,
                     input logic [3:0] pul, input logic chk_ow);
    vec_t v;
    v.id = id; v.hold = hold; v.dig = dig; v.cnt = cnt; v.lck = lck;
    v.val = val; v.pul = pul; v.chk_ow = chk_ow;
    tbl.push_back(v);
  endtask

  task automatic press(input logic [3:0] id, input int hold, input logic [3:0] exp_pul);
    @(negedge clk);
    keydown = 1'b1;
    key_id  = id;
    if (exp_pul != 4'b0000) sb.push_back(exp_pul);
    @(negedge clk);
    chk("pulse_timing", {28'd0, pulses()}, {28'd0, exp_pul});
    repeat (hold - 1) @(negedge clk);
    keydown = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] dig, input logic [2:0] cnt,
                           input logic lck, input logic [15:0] val);
    chk({tag, "_digits"}, {16'd0, digits}, {16'd0, dig});
    chk({tag, "_count"}, {29'd0, digit_count}, {29'd0, cnt});
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, lck});
    chk({tag, "_value"}, {16'd0, value}, {16'd0, val});
  endtask

  initial begin
    add(4'd1,  3, 16'h0001, 3'd1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd2,  3, 16'h0012, 3'd2, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd3,  3, 16'h0123, 3'd3, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd15, 3, 16'h0000, 3'd0, 1'b0, 16'h0000, P_CLR,   1'b0);
    add(4'd5,  3, 16'h0004, 3'd1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd6,  3, 16'h0045, 3'd2, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd7,  3, 16'h0456, 3'd3, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd9,  3, 16'h4567, 3'd4, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd10, 3, 16'h4567, 3'd4, 1'b0, 16'h0000, P_ERR,   1'b1);
    add(4'd15, 3, 16'h0000, 3'd0, 1'b0, 16'h0000, P_CLR,   1'b0);
    add(4'd11, 3, 16'h0009, 3'd1, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd9,  3, 16'h0097, 3'd2, 1'b0, 16'h0000, 4'b0000, 1'b0);
    add(4'd12, 3, 16'h0097, 3'd2, 1'b1, 16'h0097, P_VV,    1'b0);
    add(4'd1,  3, 16'h0097, 3'd2, 1'b1, 16'h0097, P_ERR,   1'b0);
    add(4'd12, 3, 16'h0097, 3'd2, 1'b1, 16'h0097, P_ERR,   1'b0);
    add(4'd14, 3, 16'h0097, 3'd2, 1'b1, 16'h0097, P_ST,    1'b0);
    add(4'd15, 3, 16'h0000, 3'd0, 1'b0, 16'h0097, P_CLR,   1'b0);
    add(4'd12, 3, 16'h0000, 3'd0, 1'b0, 16'h0097, P_ERR,   1'b0);
    add(4'd0,  3, 16'h0000, 3'd0, 1'b0, 16'h0097, P_ERR,   1'b0);
    add(4'd4,  3, 16'h0000, 3'd0, 1'b0, 16'h0097, P_ERR,   1'b0);
    add(4'd8,  3, 16'h0000, 3'd0, 1'b0, 16'h0097, P_ERR,   1'b0);
    add(4'd13, 3, 16'h0000, 3'd1, 1'b0, 16'h0097, 4'b0000, 1'b0);
    add(4'd13, 3, 16'h0000, 3'd2, 1'b0, 16'h0097, 4'b0000, 1'b0);
    add(4'd14, 20, 16'h0000, 3'd2, 1'b0, 16'h0097, P_ST,   1'b0);

    rst = 1'b0; keydown = 1'b0; key_id = 4'd0;
    #2 rst = 1'b1;
    #2 chk_state("reset", 16'h0000, 3'd0, 1'b0, 16'h0000);
    chk("reset_pulses", {28'd0, pulses()}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].id, tbl[i].hold, tbl[i].pul);
      chk_state($sformatf("vec%0d", i), tbl[i].dig, tbl[i].cnt, tbl[i].lck, tbl[i].val);
      if (tbl[i].chk_ow) begin
        chk("ow_digits", {16'd0, digits1}, 32'h5678);
        chk("ow_count", {29'd0, digit_count1}, 32'd4);
        chk("ow_no_error", ow_err, 32'd0);
      end
    end

    // Asynchronous reset mid-entry, with a key held through deassertion
    press(4'd15, 3, P_CLR);
    press(4'd1, 3, 4'b0000);
    press(4'd2, 3, 4'b0000);
    chk_state("pre_rst", 16'h0012, 3'd2, 1'b0, 16'h0097);
    @(negedge clk);
    #2 rst = 1'b1; keydown = 1'b1; key_id = 4'd13;
    #1 chk_state("async_rst", 16'h0000, 3'd0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_state("post_rst", 16'h0000, 3'd1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("post_rst_held", {29'd0, digit_count}, 32'd1);
    keydown = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Parametrised keypad front end that turns raw 4x4 keypad events into a multi-digit decimal entry plus single-cycle command pulses.
- Detects `keydown` rising edges and maps key IDs to digits or commands (start/clear/confirm).
- Accumulates up to DIGITS BCD digits, shift-register style; on confirm it latches the entry and locks until cleared.
- Sits between the keypad scanner and the countdown controller, replacing per-key decoding with a complete number-entry function.

Parameters:
- DIGITS, 4, maximum number of BCD digits held (1..8).
- OVERWRITE, 0, 0 = digit keys ignored when buffer full; 1 = oldest digit shifted out and new digit accepted.
- CNT_W, $clog2(DIGITS+1), width of digit_count (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- keydown  in  1  keypad key-pressed level, already synchronised to clk.
- key_id  in  4  scanner key ID, valid whenever keydown=1.
- digits  out  4*DIGITS  live BCD entry; digit 0 (least significant) in [3:0], most recent key in digit 0.
- digit_count  out  CNT_W  number of digits entered, 0..DIGITS.
- locked  out  1  1 after a successful confirm; entry frozen.
- value  out  4*DIGITS  BCD value latched at confirm; holds until next confirm.
- value_valid  out  1  one-cycle pulse when value is updated.
- start_pulse  out  1  one-cycle pulse on start key.
- clear_pulse  out  1  one-cycle pulse on clear key.
- error_pulse  out  1  one-cycle pulse on rejected key (see below).

Behaviour:
- Reset (async, rst=1):
  - digits=0, digit_count=0, locked=0, value=0.
  - All pulses 0; keydown history register = 0.
- Key event: ev = keydown & ~keydown_q, where keydown_q is the registered previous keydown.
  - A held key produces exactly one event.
  - key_id is sampled in the ev cycle.
  - All outputs respond on the next clk edge (1-cycle latency).
- Key map (key_id -> function):
  - Digits: 1->1, 2->2, 3->3, 5->4, 6->5, 7->6, 9->7, 10->8, 11->9, 13->0.
  - Commands: 14 = start, 15 = clear, 12 = confirm.
  - IDs 0, 4, 8 are letter keys: invalid.
- States: EDIT (locked=0) and LOCKED (locked=1).
- EDIT, digit key:
  - If digit_count<DIGITS: digits <= {digits[4*DIGITS-5:0], d}; digit_count++.
  - If full and OVERWRITE=1: same shift, digit_count stays DIGITS.
  - If full and OVERWRITE=0: no change; error_pulse.
- EDIT, confirm:
  - If digit_count>0: value<=digits, value_valid pulse, go LOCKED.
  - If digit_count==0: error_pulse only.
- LOCKED: digit or confirm -> error_pulse, no state change.
- Any state, clear:
  - digits=0, digit_count=0, go EDIT, clear_pulse.
  - value is NOT cleared.
- Any state, start: start_pulse only; entry and state untouched.
- Invalid key in any state: error_pulse, nothing else.
- Pulses are exactly one cycle wide and mutually exclusive; at most one event per cycle by construction.
- Leading zeros are kept in digits but not counted specially: "0","0" gives digit_count=2, digits=0.
- Reset mid-entry: everything returns to reset values immediately, regardless of clk.
- keydown held across reset deassertion: keydown_q=0 after reset, so the first clk edge with keydown=1 is an event.

Test Plan:
- Reset, then press/release ids 1,2,3 (keydown 3 cycles each) -> digit_count=3, digits[11:0]=0x123, no pulses besides none; value_valid never asserted.
- Press 5,6,7,9,10 with DIGITS=4, OVERWRITE=0 -> digits=0x4567, digit_count=4, error_pulse exactly once on the 5th press; with OVERWRITE=1 -> digits=0x5678, no error.
- Enter 9,7 (ids 11,9), press confirm (id 12) -> value=0x0097, one value_valid pulse one cycle after the edge, locked=1; then press id 1 -> error_pulse, digits unchanged.
- In LOCKED press clear (15) -> clear_pulse, locked=0, digit_count=0, value still 0x0097; confirm with empty buffer -> error_pulse, no value_valid.
- Hold id 14 for 20 cycles -> exactly one start_pulse; press id 0, 4, 8 -> three error_pulses, state unchanged.
- Assert rst mid-entry (after 2 digits) between clock edges -> outputs zero immediately; release with keydown=1, id 13 -> one digit 0 accepted, digit_count=1.
